// File: rtl/sxr_io_pkg.sv
// Shared I/O constants for the sxrRISC621 switch path.
// SW_WIDTH is the core's SW_in width; DEFAULT_STABLE_CNT is the debounce hold time in cycles.
package sxr_io_pkg;
  localparam int unsigned SW_WIDTH           = 5;
  localparam int unsigned DEFAULT_STABLE_CNT = 4;
endpackage

// File: rtl/sxr_debounce_bit.sv
// One-bit switch conditioner: two-flop synchronizer, stability counter, debounced level
// and registered rise/fall strobes.
// Ports:
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   raw_i      raw switch level from the pin
//   level_o    debounced level
//   rise_o     one-cycle pulse when level_o goes 0->1
//   fall_o     one-cycle pulse when level_o goes 1->0
//   strobe_d_o next-cycle value of rise_o|fall_o, lets the top register SW_changed in step
module sxr_debounce_bit #(
  parameter int unsigned STABLE_CNT = 4  // must be >= 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic strobe_d_o
);

  localparam int unsigned CntW = $clog2(STABLE_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CNT - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      // Any return to the current level, including mid-bounce, restarts the count.
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign strobe_d_o = rise_d | fall_d;

endmodule

// File: rtl/sxr_sw_debounce.sv
// Switch input conditioner placed in front of the sxrRISC621 SW_in port. Every bit is
// synchronized and debounced independently; SW_out feeds the core directly.
// Ports:
//   Clock      system clock, rising edge
//   Reset      asynchronous active-high reset
//   SW_raw     raw switch levels from the pins
//   SW_out     debounced levels
//   SW_rise    per-bit one-cycle 0->1 strobes
//   SW_fall    per-bit one-cycle 1->0 strobes
//   SW_changed one-cycle pulse when any strobe fires
module sxr_sw_debounce
  import sxr_io_pkg::*;
#(
  parameter int unsigned WIDTH      = SW_WIDTH,
  parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW_out,
  output logic [WIDTH-1:0] SW_rise,
  output logic [WIDTH-1:0] SW_fall,
  output logic             SW_changed
);

  logic [WIDTH-1:0] strobe_d;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sxr_debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .raw_i     (SW_raw[i]),
      .level_o   (SW_out[i]),
      .rise_o    (SW_rise[i]),
      .fall_o    (SW_fall[i]),
      .strobe_d_o(strobe_d[i])
    );
  end

  // Registered from the per-bit next-state strobes so it lines up with SW_rise/SW_fall.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |strobe_d;
    end
  end

  assign SW_changed = changed_q;

endmodule
